bank_host: RTL and testbench

Serial-link initiator that drives the single-wire command/data protocol of the `bank` SRAM macro. It accepts parallel read/write requests from core logic, serialises each one into a chip-select framed bitstream (opcode, address, write data), and for reads deserialises the 128-bit word the bank returns. It sits between the core request fabric and a `bank` instance, one `bank_host` per bank.

---
 rtl/bank_link_pkg.sv | 30 +++
 rtl/bank_link_shifter.sv | 45 ++++
 rtl/bank_host.sv | 211 +++++++++++++++++++++
 tb/tb_bank_host.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_link_pkg.sv
// ---------------------------------------------------------------------------
// bank_link_pkg
// Shared definitions for the single-wire serial link to the `bank` SRAM
// macro. Used by the host-side initiator (bank_host) and by the bank-side
// serial decoder.
//   LINK_ADDR_W / LINK_DATA_W / LINK_TURNAROUND : default geometry
//   LINK_CNT_W                                  : bit-counter width
//   OP_READ / OP_WRITE                          : opcode bit values
//   link_state_t                                : frame sequencer states
// ---------------------------------------------------------------------------
package bank_link_pkg;

   localparam int LINK_ADDR_W     = 7;
   localparam int LINK_DATA_W     = 128;
   localparam int LINK_TURNAROUND = 2;
   localparam int LINK_CNT_W      = 8;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_WDATA = 3'd2,
      ST_TURN  = 3'd3,
      ST_RDATA = 3'd4,
      ST_GAP   = 3'd5
   } link_state_t;

endpackage : bank_link_pkg

// File: rtl/bank_link_shifter.sv
// ---------------------------------------------------------------------------
// bank_link_shifter
// WIDTH-bit shift register for the serial link data phase.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : parallel load of data_i (has priority over shift_i)
//   data_i        : parallel load value
//   shift_i       : shift left by one; MSB leaves, ser_i enters at LSB
//   ser_i         : serial input bit
//   q_o           : register contents (q_o[WIDTH-1] is the outgoing bit)
// ---------------------------------------------------------------------------
module bank_link_shifter #(
   parameter int WIDTH = 128
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             shift_i,
   input  logic             ser_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load_i) begin
         q_d = data_i;
      end else if (shift_i) begin
         q_d = {q_q[WIDTH-2:0], ser_i};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule : bank_link_shifter

// File: rtl/bank_host.sv
// ---------------------------------------------------------------------------
// bank_host
// Serial-link initiator for one `bank` SRAM macro. Takes parallel read/write
// requests, sends a chip-select framed MSB-first bitstream
// (opcode, address, [write data]) and, for reads, collects the returned word.
//
// Request handshake: a request transfers on the rising edge where
// req_valid && req_ready. req_ready is a register (high only in IDLE) with no
// combinational path from req_valid; the requester holds req_valid and the
// request fields stable until that edge. rsp_valid / wr_done are one-cycle
// pulses without backpressure.
//
// Ports
//   vsi_clk, vsi_reset_n       : clock, asynchronous active-low reset
//   req_valid/req_ready        : request handshake
//   req_write/req_addr/req_wdata : request fields (wdata ignored for reads)
//   rsp_valid/rsp_rdata        : read completion pulse / last read word
//   wr_done                    : write completion pulse
//   vsi_chipSelect             : frame enable to the bank
//   vsi_serialOut/vsi_serialIn : bitstream to / from the bank
//   dbg_state_o                : current sequencer state (link_state_t)
// ---------------------------------------------------------------------------
module bank_host
   import bank_link_pkg::*;
#(
   parameter int ADDR_W     = LINK_ADDR_W,
   parameter int DATA_W     = LINK_DATA_W,
   parameter int TURNAROUND = LINK_TURNAROUND
) (
   input  logic              vsi_clk,
   input  logic              vsi_reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              wr_done,
   output logic              vsi_chipSelect,
   output logic              vsi_serialOut,
   input  logic              vsi_serialIn,
   output logic [2:0]        dbg_state_o
);

   // Counter reload values: phase length minus one.
   localparam logic [LINK_CNT_W-1:0] CMD_LAST  = LINK_CNT_W'(ADDR_W);
   localparam logic [LINK_CNT_W-1:0] DATA_LAST = LINK_CNT_W'(DATA_W - 1);
   localparam logic [LINK_CNT_W-1:0] TURN_LAST =
      LINK_CNT_W'((TURNAROUND > 0) ? (TURNAROUND - 1) : 0);

   link_state_t             state_q, state_d;
   logic [LINK_CNT_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic                    op_q, op_d;

   logic                    cs_q, cs_d;
   logic                    sout_q, sout_d;
   logic                    ready_q, ready_d;
   logic                    wr_done_q, wr_done_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;

   logic                    accept;
   logic                    sh_shift;
   logic [DATA_W-1:0]       sh_q;

   assign accept   = req_valid && ready_q;
   assign sh_shift = (state_q == ST_WDATA) || (state_q == ST_RDATA);

   // Write data is loaded on accept and shifted out MSB-first during WDATA;
   // read data enters at the LSB during RDATA. A read also loads req_wdata,
   // but all DATA_W bits are replaced before the word is reported.
   bank_link_shifter #(
      .WIDTH (DATA_W)
   ) u_shifter (
      .clk_i   (vsi_clk),
      .rst_ni  (vsi_reset_n),
      .load_i  (accept),
      .data_i  (req_wdata),
      .shift_i (sh_shift),
      .ser_i   (vsi_serialIn),
      .q_o     (sh_q)
   );

   // ---------------------------------------------------------------- state
   always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
      if (!vsi_reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         op_q        <= OP_READ;
         cs_q        <= 1'b0;
         sout_q      <= 1'b0;
         ready_q     <= 1'b1;
         wr_done_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         op_q        <= op_d;
         cs_q        <= cs_d;
         sout_q      <= sout_d;
         ready_q     <= ready_d;
         wr_done_q   <= wr_done_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      op_d    = op_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_CMD;
               cnt_d   = CMD_LAST;
               addr_d  = req_addr;
               op_d    = req_write;
            end
         end
         ST_CMD: begin
            if (cnt_q == '0) begin
               if (op_q == OP_WRITE) begin
                  state_d = ST_WDATA;
                  cnt_d   = DATA_LAST;
               end else if (TURNAROUND > 0) begin
                  state_d = ST_TURN;
                  cnt_d   = TURN_LAST;
               end else begin
                  state_d = ST_RDATA;
                  cnt_d   = DATA_LAST;
               end
            end else begin
               cnt_d  = cnt_q - 1'b1;
               // The opcode occupies the first CMD cycle, so the address
               // register only advances while address bits remain.
               addr_d = addr_q << 1;
            end
         end
         ST_WDATA: begin
            if (cnt_q == '0) state_d = ST_GAP;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_TURN: begin
            if (cnt_q == '0) begin
               state_d = ST_RDATA;
               cnt_d   = DATA_LAST;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RDATA: begin
            if (cnt_q == '0) state_d = ST_GAP;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_GAP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------- outputs
   // Outputs are registered, so each _d value is what the pins show in the
   // cycle after the current edge. sout_d therefore looks one bit ahead.
   always_comb begin
      cs_d        = (state_d == ST_CMD) || (state_d == ST_WDATA) ||
                    (state_d == ST_TURN) || (state_d == ST_RDATA);
      ready_d     = (state_d == ST_IDLE);
      wr_done_d   = (state_q == ST_WDATA) && (cnt_q == '0);
      rsp_valid_d = (state_q == ST_RDATA) && (cnt_q == '0);
      rsp_rdata_d = rsp_rdata_q;
      sout_d      = 1'b0;
      if (rsp_valid_d) begin
         rsp_rdata_d = {sh_q[DATA_W-2:0], vsi_serialIn};
      end
      case (state_q)
         ST_IDLE: begin
            if (accept) sout_d = req_write;
         end
         ST_CMD: begin
            if (cnt_q != '0)            sout_d = addr_q[ADDR_W-1];
            else if (op_q == OP_WRITE)  sout_d = sh_q[DATA_W-1];
         end
         ST_WDATA: begin
            if (cnt_q != '0) sout_d = sh_q[DATA_W-2];
         end
         default: begin
            sout_d = 1'b0;
         end
      endcase
   end

   assign req_ready      = ready_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_rdata      = rsp_rdata_q;
   assign wr_done        = wr_done_q;
   assign vsi_chipSelect = cs_q;
   assign vsi_serialOut  = sout_q;
   assign dbg_state_o    = state_q;

endmodule : bank_host

// File: tb/tb_bank_host.sv
// ---------------------------------------------------------------------------
// tb_bank_host
// Directed bench for bank_host with a behavioural bank on the serial wires.
// Stimulus tasks push expected frames and completion events into queues;
// independent negedge monitors pop and compare as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_bank_host;
   import bank_link_pkg::*;

   localparam int AW = 7;
   localparam int DW = 128;
   localparam int TA = 2;
   localparam int FIRST_RD_K = 1 + AW + TA + 1;

   logic          vsi_clk;
   logic          vsi_reset_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          wr_done;
   logic          vsi_chipSelect;
   logic          vsi_serialOut;
   logic          vsi_serialIn;
   logic [2:0]    dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [DW-1:0]  mem [0:(1<<AW)-1];

   // scoreboard queues
   logic [255:0]  fexp_bits_q[$];
   int            fexp_len_q[$];
   int            fexp_gap_q[$];
   logic          ev_kind_q[$];
   logic [DW-1:0] exp_q[$];
   int            ev_cyc_q[$];

   bank_host #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .TURNAROUND (TA)
   ) dut (
      .vsi_clk        (vsi_clk),
      .vsi_reset_n    (vsi_reset_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_rdata      (rsp_rdata),
      .wr_done        (wr_done),
      .vsi_chipSelect (vsi_chipSelect),
      .vsi_serialOut  (vsi_serialOut),
      .vsi_serialIn   (vsi_serialIn),
      .dbg_state_o    (dbg_state)
   );

   // ------------------------------------------------------ clock / reset
   initial vsi_clk = 1'b0;
   always #5 vsi_clk = ~vsi_clk;
   always @(posedge vsi_clk) cyc <= cyc + 1;

   // ------------------------------------------------------------ helpers
   task automatic chk(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one request; must be called at a negedge. n = accept cycle.
   task automatic send(input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                       input logic keep, input int gap, output int n);
      logic [255:0] bits;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = d;
      n = -1;
      for (int t = 0; t < 400 && req_ready !== 1'b1; t++) @(negedge vsi_clk);
      if (req_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: req_ready=%b after 400 cycles, expected 1", req_ready);
         req_valid = 1'b0;
         return;
      end
      n = cyc;
      if (wr) begin
         bits = 256'({1'b1, a, d});
         fexp_len_q.push_back(1 + AW + DW);
         ev_cyc_q.push_back(n + 137);
      end else begin
         bits = 256'({1'b0, a}) << (TA + DW);
         fexp_len_q.push_back(1 + AW + TA + DW);
         ev_cyc_q.push_back(n + 139);
      end
      fexp_bits_q.push_back(bits);
      fexp_gap_q.push_back(gap);
      ev_kind_q.push_back(!wr);
      exp_q.push_back(exp_rd);
      @(negedge vsi_clk);
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 1000 && (ev_kind_q.size() != 0 || fexp_len_q.size() != 0); t++)
         @(negedge vsi_clk);
      chk("drain_events_left", DW'(ev_kind_q.size()), '0);
      chk("drain_frames_left", DW'(fexp_len_q.size()), '0);
   endtask

   // ------------------------------------ bank model + frame monitor
   int           k = 0;
   int           low_cnt = 1000;
   int           gap_seen = 0;
   logic [255:0] cap = '0;
   logic         f_op = 1'b0;
   logic [AW-1:0] f_addr = '0;

   initial vsi_serialIn = 1'b0;

   always @(negedge vsi_clk) begin
      if (!vsi_reset_n) begin
         k = 0;
         cap = '0;
         low_cnt = 1000;
         vsi_serialIn = 1'b0;
      end else if (vsi_chipSelect) begin
         if (k == 0) begin
            gap_seen = low_cnt;
            low_cnt = 0;
            cap = '0;
         end
         k++;
         cap = {cap[254:0], vsi_serialOut};
         if (k == 1) f_op = vsi_serialOut;
         else if (k <= 1 + AW) f_addr = {f_addr[AW-2:0], vsi_serialOut};
         if (f_op == OP_READ && k >= FIRST_RD_K && k < FIRST_RD_K + DW)
            vsi_serialIn = mem[f_addr][DW-1-(k-FIRST_RD_K)];
         else
            vsi_serialIn = 1'b0;
      end else begin
         vsi_serialIn = 1'b0;
         checks++;
         if (vsi_serialOut !== 1'b0) begin
            errors++;
            $display("FAIL sout_idle: serialOut=%b with chipSelect low, expected 0", vsi_serialOut);
         end
         if (k > 0) begin
            if (f_op == OP_WRITE && k == 1 + AW + DW) mem[f_addr] = cap[DW-1:0];
            checks++;
            if (fexp_len_q.size() == 0) begin
               errors++;
               $display("FAIL frame_unexpected: %0d-bit frame seen, none expected", k);
            end else begin
               int           elen;
               int           egap;
               logic [255:0] ebits;
               elen  = fexp_len_q.pop_front();
               egap  = fexp_gap_q.pop_front();
               ebits = fexp_bits_q.pop_front();
               if (k != elen) begin
                  errors++;
                  $display("FAIL frame_len: got %0d cycles expected %0d", k, elen);
               end else if (cap !== ebits) begin
                  errors++;
                  $display("FAIL frame_bits: got %h expected %h", cap, ebits);
               end else if (egap >= 0 && gap_seen != egap) begin
                  errors++;
                  $display("FAIL frame_gap: got %0d cs-low cycles expected %0d", gap_seen, egap);
               end
            end
            k = 0;
         end
         if (low_cnt < 1000) low_cnt++;
      end
   end

   // --------------------------------------------------- event monitor
   always @(negedge vsi_clk) begin
      if (vsi_reset_n && (rsp_valid || wr_done)) begin
         checks++;
         if (ev_kind_q.size() == 0) begin
            errors++;
            $display("FAIL event_unexpected: rsp_valid=%b wr_done=%b, none expected", rsp_valid, wr_done);
         end else begin
            logic          ekind;
            logic [DW-1:0] edata;
            int            ecyc;
            ekind = ev_kind_q.pop_front();
            edata = exp_q.pop_front();
            ecyc  = ev_cyc_q.pop_front();
            if (rsp_valid && wr_done) begin
               errors++;
               $display("FAIL event_both: rsp_valid and wr_done together, expected one");
            end else if (rsp_valid !== ekind) begin
               errors++;
               $display("FAIL event_kind: got rsp_valid=%b expected %b", rsp_valid, ekind);
            end else if (cyc != ecyc) begin
               errors++;
               $display("FAIL event_cycle: got %0d expected %0d", cyc, ecyc);
            end else if (ekind && rsp_rdata !== edata) begin
               errors++;
               $display("FAIL rsp_rdata: got %h expected %h", rsp_rdata, edata);
            end
         end
      end
   end

   // --------------------------------------------------------- stimulus
   localparam logic [DW-1:0] PAT_A5   = {16{8'hA5}};
   localparam logic [DW-1:0] PAT_7F   = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [DW-1:0] PAT_DEAD = 128'hDEADBEEF_00000000_FFFFFFFF_12345678;

   initial begin
      int n1, n2, nr;
      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      mem[7'h7F] = PAT_7F;
      vsi_reset_n = 1'b0;
      req_valid   = 1'b0;
      req_write   = 1'b0;
      req_addr    = '0;
      req_wdata   = '0;
      repeat (3) @(negedge vsi_clk);
      vsi_reset_n = 1'b1;
      @(negedge vsi_clk);

      chk("reset_req_ready", DW'(req_ready), DW'(1));
      chk("reset_cs", DW'(vsi_chipSelect), '0);
      chk("reset_rsp_valid", DW'(rsp_valid), '0);
      chk("reset_rsp_rdata", rsp_rdata, '0);
      chk("reset_wr_done", DW'(wr_done), '0);
      chk("reset_state", DW'(dbg_state), DW'(ST_IDLE));

      // single write, then single read
      send(1'b1, 7'h05, PAT_A5, '0, 1'b0, -1, n1);
      send(1'b0, 7'h7F, '0, PAT_7F, 1'b0, -1, n1);

      // back-to-back write -> read with req_valid held
      send(1'b1, 7'h2A, PAT_DEAD, '0, 1'b1, -1, n1);
      send(1'b0, 7'h05, '0, PAT_A5, 1'b0, 2, n2);
      chk("b2b_wr_rd_spacing", DW'(n2 - n1), DW'(138));

      // back-to-back read -> write
      send(1'b0, 7'h2A, '0, PAT_DEAD, 1'b1, -1, n1);
      send(1'b1, 7'h00, 128'h1, '0, 1'b0, 2, n2);
      chk("b2b_rd_wr_spacing", DW'(n2 - n1), DW'(140));
      drain();
      chk("rdata_held_after_write", rsp_rdata, PAT_DEAD);

      // reset at cycle 60 of a read
      send(1'b0, 7'h7F, '0, PAT_7F, 1'b0, -1, nr);
      for (int t = 0; t < 200 && cyc < nr + 60; t++) @(negedge vsi_clk);
      #2;
      vsi_reset_n = 1'b0;
      fexp_bits_q.delete();
      fexp_len_q.delete();
      fexp_gap_q.delete();
      ev_kind_q.delete();
      exp_q.delete();
      ev_cyc_q.delete();
      #1;
      chk("midreset_cs_async", DW'(vsi_chipSelect), '0);
      chk("midreset_sout", DW'(vsi_serialOut), '0);
      @(negedge vsi_clk);
      chk("midreset_rsp_rdata", rsp_rdata, '0);
      chk("midreset_rsp_valid", DW'(rsp_valid), '0);
      repeat (2) @(negedge vsi_clk);
      vsi_reset_n = 1'b1;
      @(negedge vsi_clk);
      chk("postreset_req_ready", DW'(req_ready), DW'(1));
      chk("postreset_state", DW'(dbg_state), DW'(ST_IDLE));

      send(1'b0, 7'h7F, '0, PAT_7F, 1'b0, -1, nr);
      send(1'b0, 7'h05, '0, PAT_A5, 1'b0, 2, n2);
      drain();
      chk("final_rdata", rsp_rdata, PAT_A5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_bank_host
